// File: rtl/uart_echo_pkg.sv
// Shared constants, state encoding and LFSR step for the UART echo tester.
package uart_echo_pkg;

    localparam logic [7:0] HEADER_BYTE_DEF = 8'hAA;
    localparam logic [7:0] LFSR_TAPS       = 8'hB8;

    typedef enum logic [2:0] {
        IDLE,
        SEND_HDR,
        WAIT_HDR_TX,
        SEND_DATA,
        WAIT_DATA_TX,
        WAIT_ECHO,
        NEXT,
        REPORT
    } tester_state_t;

    // Left-shifting Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_step(input logic [7:0] value);
        return {value[6:0], ^(value & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/uart_payload_gen.sv
// Payload byte generator: incrementing counter by default,
// 8-bit LFSR when UART_ECHO_TESTER_LFSR_EN is defined.
module uart_payload_gen
    import uart_echo_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [7:0] i_seed,
    input  logic       i_advance,
    output logic [7:0] o_byte
);

    logic [7:0] next_byte_c;

`ifdef UART_ECHO_TESTER_LFSR_EN
    assign next_byte_c = lfsr_step(o_byte);
`else
    assign next_byte_c = o_byte + 8'd1;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_byte <= 8'h00;
        end else if (i_load) begin
            o_byte <= i_seed;
        end else if (i_advance) begin
            o_byte <= next_byte_c;
        end
    end

endmodule

// File: rtl/uart_echo_tester.sv
// Stop-and-wait UART echo initiator: header, then payload bytes each checked
// against its echo. UART_ECHO_TESTER_LFSR_EN selects the LFSR payload.
module uart_echo_tester
    import uart_echo_pkg::*;
#(
    parameter int unsigned PAYLOAD_LEN    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50_000,
    parameter logic [7:0]  HEADER_BYTE    = HEADER_BYTE_DEF,
    parameter logic [7:0]  SEED           = 8'h41
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic       o_tx_dv,
    output logic [7:0] o_tx_byte,
    input  logic       i_tx_active,
    input  logic       i_tx_done,
    input  logic       i_rx_dv,
    input  logic [7:0] i_rx_byte,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [7:0] o_err_count,
    output logic       o_timeout
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    tester_state_t      state;
    logic [7:0]         idx;
    logic [TIMER_W-1:0] timer;
    logic               hold_valid;
    logic [7:0]         hold_byte;
    logic [7:0]         expected;

    logic               gen_load_c;
    logic               gen_advance_c;
    logic               echo_valid_c;
    logic [7:0]         echo_byte_c;
    logic [7:0]         err_inc_c;

    assign gen_load_c    = (state == IDLE) && i_start;
    assign gen_advance_c = (state == NEXT);
    // An echo latched before i_tx_done takes precedence over the live strobe.
    assign echo_valid_c  = hold_valid || i_rx_dv;
    assign echo_byte_c   = hold_valid ? hold_byte : i_rx_byte;
    assign err_inc_c     = (o_err_count == 8'hFF) ? o_err_count : o_err_count + 8'd1;

    uart_payload_gen u_gen (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (gen_load_c),
        .i_seed    (SEED),
        .i_advance (gen_advance_c),
        .o_byte    (expected)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            o_tx_dv     <= 1'b0;
            o_tx_byte   <= 8'h00;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_err_count <= 8'h00;
            o_timeout   <= 1'b0;
            idx         <= 8'h00;
            timer       <= '0;
            hold_valid  <= 1'b0;
            hold_byte   <= 8'h00;
        end else begin
            o_tx_dv <= 1'b0;
            o_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_err_count <= 8'h00;
                        o_timeout   <= 1'b0;
                        o_pass      <= 1'b0;
                        o_busy      <= 1'b1;
                        idx         <= 8'h00;
                        hold_valid  <= 1'b0;
                        state       <= SEND_HDR;
                    end
                end
                SEND_HDR: begin
                    if (!i_tx_active) begin
                        o_tx_dv   <= 1'b1;
                        o_tx_byte <= HEADER_BYTE;
                        state     <= WAIT_HDR_TX;
                    end
                end
                WAIT_HDR_TX: begin
                    if (i_tx_done) begin
                        state <= SEND_DATA;
                    end
                end
                SEND_DATA: begin
                    if (!i_tx_active) begin
                        o_tx_dv   <= 1'b1;
                        o_tx_byte <= expected;
                        state     <= WAIT_DATA_TX;
                    end
                end
                WAIT_DATA_TX: begin
                    // The receiver can finish before our stop bit does.
                    if (i_rx_dv && !hold_valid) begin
                        hold_valid <= 1'b1;
                        hold_byte  <= i_rx_byte;
                    end
                    if (i_tx_done) begin
                        timer <= '0;
                        state <= WAIT_ECHO;
                    end
                end
                WAIT_ECHO: begin
                    if (echo_valid_c) begin
                        hold_valid <= 1'b0;
                        if (echo_byte_c != expected) begin
                            o_err_count <= err_inc_c;
                        end
                        state <= NEXT;
                    end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                        o_err_count <= err_inc_c;
                        o_timeout   <= 1'b1;
                        state       <= NEXT;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                NEXT: begin
                    idx   <= idx + 8'd1;
                    state <= (idx == 8'(PAYLOAD_LEN - 1)) ? REPORT : SEND_DATA;
                end
                REPORT: begin
                    o_done <= 1'b1;
                    o_pass <= (o_err_count == 8'h00);
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
